// File: rtl/muldiv_pkg.sv
// Shared constants and op encodings for the iterative RV32M multiply/divide unit.
// The op encodings match the funct3 field used by the cpu_top decoder.
package muldiv_pkg;

  localparam int XLEN       = 32;
  localparam int HART_ID_W  = 1;
  localparam int REG_ADDR_W = 5;
  localparam int CNT_W      = $clog2(XLEN) + 1;

  typedef enum logic [2:0] {
    OP_MUL    = 3'd0,
    OP_MULH   = 3'd1,
    OP_MULHSU = 3'd2,
    OP_MULHU  = 3'd3,
    OP_DIV    = 3'd4,
    OP_DIVU   = 3'd5,
    OP_REM    = 3'd6,
    OP_REMU   = 3'd7
  } muldiv_op_e;

  function automatic logic op_a_signed(input logic [2:0] op);
    return op inside {OP_MUL, OP_MULH, OP_MULHSU, OP_DIV, OP_REM};
  endfunction

  function automatic logic op_b_signed(input logic [2:0] op);
    return op inside {OP_MUL, OP_MULH, OP_DIV, OP_REM};
  endfunction

endpackage

// File: rtl/muldiv_abs_neg.sv
// Conditional two's-complement negate; used both to take operand magnitudes
// and to restore the sign of a finished result.
module muldiv_abs_neg #(
  parameter int W = 32
) (
  input  logic         i_neg,
  input  logic [W-1:0] i_val,
  output logic [W-1:0] o_val
);

  assign o_val = i_neg ? -i_val : i_val;

endmodule

// File: rtl/muldiv_unit.sv
// Iterative radix-2 RV32M multiply/divide unit shared by both harts; one tagged op
// in flight, result returned with its tag on a one-cycle done pulse.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter bit EARLY_OUT = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  muldiv_start,
  input  logic [2:0]            muldiv_op,
  input  logic [XLEN-1:0]       muldiv_a,
  input  logic [XLEN-1:0]       muldiv_b,
  input  logic [HART_ID_W-1:0]  muldiv_hart_id,
  input  logic [REG_ADDR_W-1:0] muldiv_rd,
  output logic                  muldiv_busy,
  output logic                  muldiv_done,
  output logic [XLEN-1:0]       muldiv_result,
  output logic [HART_ID_W-1:0]  muldiv_done_hart_id,
  output logic [REG_ADDR_W-1:0] muldiv_done_rd
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FIX  = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

  state_e r_state, w_state_nxt;

  logic [2*XLEN-1:0]     r_acc;
  logic [XLEN-1:0]       r_opnd_b;
  logic [CNT_W-1:0]      r_cnt;
  logic [2:0]            r_op;
  logic                  r_neg_a, r_neg_b, r_div0;
  logic [HART_ID_W-1:0]  r_hart;
  logic [REG_ADDR_W-1:0] r_rd;
  logic [XLEN-1:0]       r_res;
  logic                  r_done;
  logic [XLEN-1:0]       r_result;
  logic [HART_ID_W-1:0]  r_done_hart;
  logic [REG_ADDR_W-1:0] r_done_rd;

  logic              w_accept, w_neg_a, w_neg_b, w_div0, w_ovf, w_fast;
  logic [XLEN-1:0]   w_mag_a, w_mag_b, w_special_res;
  logic [XLEN:0]     w_mul_sum, w_rem_sh;
  logic [XLEN-1:0]   w_rem_sub;
  logic              w_div_ge;
  logic [2*XLEN-1:0] w_mul_nxt, w_div_nxt, w_prod_fix;
  logic [XLEN-1:0]   w_div_val, w_div_fix, w_fix_res;
  logic              w_div_neg;

  assign w_accept = muldiv_start && (r_state == ST_IDLE || r_state == ST_DONE);
  assign w_neg_a  = op_a_signed(muldiv_op) && muldiv_a[XLEN-1];
  assign w_neg_b  = op_b_signed(muldiv_op) && muldiv_b[XLEN-1];

  // Divide-by-zero and INT_MIN/-1 have fixed architectural results.
  assign w_div0 = muldiv_op[2] && (muldiv_b == '0);
  assign w_ovf  = (muldiv_op == OP_DIV || muldiv_op == OP_REM) &&
                  (muldiv_a == INT_MIN) && (muldiv_b == '1);
  assign w_fast = EARLY_OUT && (w_div0 || w_ovf);
  assign w_special_res = w_div0 ? (muldiv_op[1] ? muldiv_a : '1)
                                : (muldiv_op[1] ? '0 : INT_MIN);

  muldiv_abs_neg #(.W(XLEN)) u_abs_a (.i_neg(w_neg_a), .i_val(muldiv_a), .o_val(w_mag_a));
  muldiv_abs_neg #(.W(XLEN)) u_abs_b (.i_neg(w_neg_b), .i_val(muldiv_b), .o_val(w_mag_b));

  // Multiply: high half accumulates, low half shifts the multiplier out LSB first.
  assign w_mul_sum = {1'b0, r_acc[2*XLEN-1:XLEN]} + (r_acc[0] ? {1'b0, r_opnd_b} : '0);
  assign w_mul_nxt = {w_mul_sum, r_acc[XLEN-1:1]};

  // Divide: high half is the partial remainder, low half shifts dividend out and quotient in.
  assign w_rem_sh  = r_acc[2*XLEN-1:XLEN-1];
  assign w_div_ge  = w_rem_sh >= {1'b0, r_opnd_b};
  assign w_rem_sub = w_rem_sh[XLEN-1:0] - r_opnd_b;
  assign w_div_nxt = {(w_div_ge ? w_rem_sub : w_rem_sh[XLEN-1:0]), r_acc[XLEN-2:0], w_div_ge};

  assign w_div_val = r_op[1] ? r_acc[2*XLEN-1:XLEN] : r_acc[XLEN-1:0];
  assign w_div_neg = r_op[1] ? r_neg_a : (r_neg_a ^ r_neg_b);

  muldiv_abs_neg #(.W(2*XLEN)) u_fix_prod (
    .i_neg(r_neg_a ^ r_neg_b), .i_val(r_acc), .o_val(w_prod_fix)
  );
  muldiv_abs_neg #(.W(XLEN)) u_fix_div (
    .i_neg(w_div_neg), .i_val(w_div_val), .o_val(w_div_fix)
  );

  // NOTE: every signal driven in always_comb gets a default first so no latch is inferred.
  always_comb begin
    w_fix_res = w_div_fix;
    if (r_op == OP_MUL)
      w_fix_res = w_prod_fix[XLEN-1:0];
    else if (!r_op[2])
      w_fix_res = w_prod_fix[2*XLEN-1:XLEN];
    else if (r_div0 && !r_op[1])
      w_fix_res = '1;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (w_accept) w_state_nxt = w_fast ? ST_DONE : ST_CALC;
      ST_CALC: if (r_cnt == CNT_W'(XLEN - 1)) w_state_nxt = ST_FIX;
      ST_FIX:  w_state_nxt = ST_DONE;
      ST_DONE: w_state_nxt = w_accept ? (w_fast ? ST_DONE : ST_CALC) : ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_acc       <= '0;
      r_opnd_b    <= '0;
      r_cnt       <= '0;
      r_op        <= '0;
      r_neg_a     <= 1'b0;
      r_neg_b     <= 1'b0;
      r_div0      <= 1'b0;
      r_hart      <= '0;
      r_rd        <= '0;
      r_res       <= '0;
      r_done      <= 1'b0;
      r_result    <= '0;
      r_done_hart <= '0;
      r_done_rd   <= '0;
    end else begin
      // Outputs publish on the edge leaving DONE, so a new op may load at the same edge.
      r_done <= (r_state == ST_DONE);
      if (r_state == ST_DONE) begin
        r_result    <= r_res;
        r_done_hart <= r_hart;
        r_done_rd   <= r_rd;
      end
      if (w_accept) begin
        r_op     <= muldiv_op;
        r_hart   <= muldiv_hart_id;
        r_rd     <= muldiv_rd;
        r_neg_a  <= w_neg_a;
        r_neg_b  <= w_neg_b;
        r_div0   <= w_div0;
        r_acc    <= {{XLEN{1'b0}}, w_mag_a};
        r_opnd_b <= w_mag_b;
        r_cnt    <= '0;
        r_res    <= w_special_res;
      end else if (r_state == ST_CALC) begin
        r_acc <= r_op[2] ? w_div_nxt : w_mul_nxt;
        r_cnt <= r_cnt + CNT_W'(1);
      end else if (r_state == ST_FIX) begin
        r_res <= w_fix_res;
      end
    end
  end

  assign muldiv_busy         = (r_state == ST_CALC) || (r_state == ST_FIX);
  assign muldiv_done         = r_done;
  assign muldiv_result       = r_result;
  assign muldiv_done_hart_id = r_done_hart;
  assign muldiv_done_rd      = r_done_rd;

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: directed ops push expected result, tags and
// done cycle; a monitor pops and compares on every done pulse.
module tb_muldiv_unit;
  import muldiv_pkg::*;

  logic                  clk = 1'b0;
  logic                  rst = 1'b1;
  logic                  muldiv_start = 1'b0;
  logic [2:0]            muldiv_op = '0;
  logic [XLEN-1:0]       muldiv_a = '0;
  logic [XLEN-1:0]       muldiv_b = '0;
  logic [HART_ID_W-1:0]  muldiv_hart_id = '0;
  logic [REG_ADDR_W-1:0] muldiv_rd = '0;
  logic                  muldiv_busy;
  logic                  muldiv_done;
  logic [XLEN-1:0]       muldiv_result;
  logic [HART_ID_W-1:0]  muldiv_done_hart_id;
  logic [REG_ADDR_W-1:0] muldiv_done_rd;

  muldiv_unit #(.EARLY_OUT(1'b1)) dut (
    .clk(clk), .rst(rst),
    .muldiv_start(muldiv_start), .muldiv_op(muldiv_op),
    .muldiv_a(muldiv_a), .muldiv_b(muldiv_b),
    .muldiv_hart_id(muldiv_hart_id), .muldiv_rd(muldiv_rd),
    .muldiv_busy(muldiv_busy), .muldiv_done(muldiv_done),
    .muldiv_result(muldiv_result),
    .muldiv_done_hart_id(muldiv_done_hart_id), .muldiv_done_rd(muldiv_done_rd)
  );

  always #5 clk = ~clk;

  localparam int LAT      = XLEN + 2;
  localparam int LAT_FAST = 1;

  typedef struct {
    string                 name;
    logic [XLEN-1:0]       res;
    logic [HART_ID_W-1:0]  hart;
    logic [REG_ADDR_W-1:0] rd;
    int                    cyc;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   n_checks = 0;
  int   n_errors = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && muldiv_done) begin
      check("done_has_pending_op", 64'(sb.size() > 0), 64'd1);
      if (sb.size() > 0) begin
        exp_t e;
        e = sb.pop_front();
        check({e.name, ".result"}, 64'(muldiv_result), 64'(e.res));
        check({e.name, ".hart"},   64'(muldiv_done_hart_id), 64'(e.hart));
        check({e.name, ".rd"},     64'(muldiv_done_rd), 64'(e.rd));
        check({e.name, ".cycle"},  64'(cyc), 64'(e.cyc));
      end
    end
  end

  task automatic wait_drain(input int budget);
    for (int i = 0; i < budget && sb.size() != 0; i++) @(posedge clk);
    check("scoreboard_drained", 64'(sb.size()), 64'd0);
    sb.delete();
  endtask

  task automatic run_op(input string name, input logic [2:0] op,
                        input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                        input logic [HART_ID_W-1:0] hart, input logic [REG_ADDR_W-1:0] rd,
                        input logic [XLEN-1:0] exp, input bit fast);
    exp_t e;
    @(posedge clk); #1;
    muldiv_op = op; muldiv_a = a; muldiv_b = b;
    muldiv_hart_id = hart; muldiv_rd = rd; muldiv_start = 1'b1;
    @(posedge clk); #1;
    muldiv_start = 1'b0;
    muldiv_a = $urandom(); muldiv_b = $urandom(); muldiv_rd = 5'($urandom());
    e.name = name; e.res = exp; e.hart = hart; e.rd = rd;
    e.cyc = cyc + (fast ? LAT_FAST : LAT);
    sb.push_back(e);
    wait_drain(LAT + 10);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    exp_t e;
    int   e0;

    repeat (3) @(posedge clk);
    #1;
    check("reset.busy",   64'(muldiv_busy), 64'd0);
    check("reset.done",   64'(muldiv_done), 64'd0);
    check("reset.result", 64'(muldiv_result), 64'd0);
    check("reset.hart",   64'(muldiv_done_hart_id), 64'd0);
    check("reset.rd",     64'(muldiv_done_rd), 64'd0);
    rst = 1'b0;

    run_op("mul_7_m3",     OP_MUL,    32'd7,         32'hFFFF_FFFD, 1'b1, 5'd5,  32'hFFFF_FFEB, 1'b0);
    run_op("mul_shift",    OP_MUL,    32'h1234_5678, 32'h0000_0010, 1'b0, 5'd3,  32'h2345_6780, 1'b0);
    run_op("mulh_min2",    OP_MULH,   32'h8000_0000, 32'h8000_0000, 1'b0, 5'd7,  32'h4000_0000, 1'b0);
    run_op("mulhu_max2",   OP_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 5'd8,  32'hFFFF_FFFE, 1'b0);
    run_op("mulhsu_m1",    OP_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 5'd9,  32'hFFFF_FFFF, 1'b0);
    run_op("div_m7_2",     OP_DIV,    32'hFFFF_FFF9, 32'd2,         1'b1, 5'd10, 32'hFFFF_FFFD, 1'b0);
    run_op("rem_m7_2",     OP_REM,    32'hFFFF_FFF9, 32'd2,         1'b0, 5'd11, 32'hFFFF_FFFF, 1'b0);
    run_op("divu_100_7",   OP_DIVU,   32'd100,       32'd7,         1'b1, 5'd12, 32'd14,        1'b0);
    run_op("remu_100_7",   OP_REMU,   32'd100,       32'd7,         1'b0, 5'd13, 32'd2,         1'b0);
    run_op("div_m20_m6",   OP_DIV,    32'hFFFF_FFEC, 32'hFFFF_FFFA, 1'b0, 5'd14, 32'd3,         1'b0);
    run_op("rem_m20_m6",   OP_REM,    32'hFFFF_FFEC, 32'hFFFF_FFFA, 1'b1, 5'd15, 32'hFFFF_FFFE, 1'b0);
    run_op("mul_rd0",      OP_MUL,    32'd9,         32'd9,         1'b1, 5'd0,  32'd81,        1'b0);
    run_op("div_5_0",      OP_DIV,    32'd5,         32'd0,         1'b0, 5'd16, 32'hFFFF_FFFF, 1'b1);
    run_op("rem_5_0",      OP_REM,    32'd5,         32'd0,         1'b1, 5'd17, 32'd5,         1'b1);
    run_op("remu_9_0",     OP_REMU,   32'd9,         32'd0,         1'b0, 5'd18, 32'd9,         1'b1);
    run_op("div_ovf",      OP_DIV,    32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 5'd19, 32'h8000_0000, 1'b1);
    run_op("rem_ovf",      OP_REM,    32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 5'd20, 32'd0,         1'b1);

    // Start held high: second accept lands in the DONE cycle of the first op.
    @(posedge clk); #1;
    muldiv_op = OP_MUL; muldiv_a = 32'd3; muldiv_b = 32'd5;
    muldiv_hart_id = 1'b1; muldiv_rd = 5'd21; muldiv_start = 1'b1;
    @(posedge clk); #1;
    e0 = cyc;
    e.name = "held_first";  e.res = 32'd15; e.hart = 1'b1; e.rd = 5'd21; e.cyc = e0 + LAT;
    sb.push_back(e);
    e.name = "held_second"; e.cyc = e0 + 2 * LAT;
    sb.push_back(e);
    repeat (10) @(posedge clk);
    #1;
    check("held.busy_mid", 64'(muldiv_busy), 64'd1);
    repeat (LAT - 10) @(posedge clk);
    #1;
    muldiv_start = 1'b0;
    wait_drain(LAT + 10);
    repeat (LAT + 10) @(posedge clk);

    // Reset in the middle of a divide: the aborted op must never report.
    @(posedge clk); #1;
    muldiv_op = OP_DIV; muldiv_a = 32'd1000; muldiv_b = 32'd3; muldiv_rd = 5'd22;
    muldiv_start = 1'b1;
    @(posedge clk); #1;
    muldiv_start = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    check("abort.busy_before", 64'(muldiv_busy), 64'd1);
    rst = 1'b1;
    #1;
    check("abort.busy", 64'(muldiv_busy), 64'd0);
    check("abort.done", 64'(muldiv_done), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (100) @(posedge clk);
    run_op("mul_6_7",      OP_MUL,    32'd6,         32'd7,         1'b0, 5'd23, 32'd42,        1'b0);

    repeat (5) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
